// File: rtl/ppu_vram_arbiter_pkg.sv
// Shared types and constants for the PPU VRAM arbiter: FSM states, the
// captured CPU request and the default address mask / palette base.
package ppu_pkg;
    localparam int          ADDR_W   = 16;
    localparam logic [15:0] VMASK    = 16'h3FFF;
    localparam logic [15:0] PAL_BASE = 16'h3F00;

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} vram_arb_state_t;
    typedef enum logic {OP_WR, OP_RD} cpu_op_t;

    typedef struct packed {
        cpu_op_t     op;
        logic [15:0] addr;
        logic [7:0]  data;
    } cpu_req_t;
endpackage

// File: rtl/ppu_vram_arbiter_if.sv
// Single VRAM port: the arbiter is the master, the memory is the slave.
interface ppu_vram_arbiter_if #(parameter int ADDR_W = 16);
    logic [ADDR_W-1:0] VRAM_addr;
    logic              VRAM_WE;
    logic [7:0]        VRAM_data_in;
    logic [7:0]        VRAM_data_out;

    modport master (output VRAM_addr, VRAM_WE, VRAM_data_in, input VRAM_data_out);
    modport slave  (input VRAM_addr, VRAM_WE, VRAM_data_in, output VRAM_data_out);
endinterface

// File: rtl/ppu_vram_arbiter_vaddr_reg.sv
// Internal VRAM address register v and the $2006 hi/lo write toggle w.
// An address write takes priority over a $2007 post-access increment.
module ppu_vaddr_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        addr_wr_stb,
    input  logic [7:0]  wdata,
    input  logic        w_clear,
    input  logic        inc_en,
    input  logic        incr32,
    output logic [14:0] v
);
    logic w;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v <= '0;
            w <= 1'b0;
        end else begin
            if (addr_wr_stb) begin
                if (!w) v[14:8] <= {1'b0, wdata[5:0]};
                else    v[7:0]  <= wdata;
            end else if (inc_en) begin
                v <= v + (incr32 ? 15'd32 : 15'd1);
            end
            // the write above already used the old w; a $2002 read still wins
            if (w_clear)          w <= 1'b0;
            else if (addr_wr_stb) w <= ~w;
        end
    end
endmodule

// File: rtl/ppu_vram_arbiter.sv
// Shares the VRAM port between render fetches (absolute priority) and one
// queued CPU $2007 access; owns the $2007 read buffer.
module ppu_vram_arbiter #(
    parameter int          ADDR_W   = 16,
    parameter logic [15:0] VMASK    = ppu_pkg::VMASK,
    parameter logic [15:0] PAL_BASE = ppu_pkg::PAL_BASE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_addr_wr_stb,
    input  logic              cpu_data_wr_stb,
    input  logic              cpu_data_rd_stb,
    input  logic [7:0]        cpu_wdata,
    input  logic              incr32,
    input  logic              w_clear,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_busy,
    output logic              cpu_overrun,
    output logic [14:0]       vaddr,
    input  logic              ren_req,
    input  logic [ADDR_W-1:0] ren_addr,
    output logic [7:0]        ren_data,
    output logic              ren_valid,
    ppu_vram_arbiter_if.master vram
);
    import ppu_pkg::*;

    vram_arb_state_t state, state_nxt;
    cpu_req_t        slot;
    logic [7:0]      rd_buf;
    logic            cpu_stb, slot_frees, accept;
    logic [15:0]     v_masked;

    assign cpu_stb  = cpu_data_wr_stb | cpu_data_rd_stb;
    assign v_masked = {1'b0, vaddr} & VMASK;
    assign cpu_busy = (state != IDLE);
    assign ren_data = ren_valid ? vram.VRAM_data_out : 8'h00;

    ppu_vaddr_reg u_vaddr (
        .clk         (clk),
        .reset       (reset),
        .addr_wr_stb (cpu_addr_wr_stb),
        .wdata       (cpu_wdata),
        .w_clear     (w_clear),
        .inc_en      (accept),
        .incr32      (incr32),
        .v           (vaddr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        slot_frees         = 1'b0;
        accept             = 1'b0;
        vram.VRAM_addr     = '0;
        vram.VRAM_WE       = 1'b0;
        vram.VRAM_data_in  = 8'h00;
        if (ren_req) vram.VRAM_addr = ren_addr;
        unique case (state)
            ISSUE: if (!ren_req) begin
                vram.VRAM_addr = ADDR_W'(slot.addr);
                if (slot.op == OP_WR) begin
                    vram.VRAM_WE      = 1'b1;
                    vram.VRAM_data_in = slot.data;
                    slot_frees        = 1'b1;
                    state_nxt         = IDLE;
                end else begin
                    state_nxt = RD_WAIT;
                end
            end
            // read data is already on VRAM_data_out, so render may own the port
            RD_WAIT: begin
                slot_frees = 1'b1;
                state_nxt  = IDLE;
            end
            default: ;
        endcase
        accept = cpu_stb && (state == IDLE || slot_frees);
        if (accept) state_nxt = ISSUE;
        if (!reset) begin
            vram.VRAM_addr    = '0;
            vram.VRAM_WE      = 1'b0;
            vram.VRAM_data_in = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot        <= '0;
            rd_buf      <= 8'h00;
            cpu_rdata   <= 8'h00;
            cpu_overrun <= 1'b0;
            ren_valid   <= 1'b0;
        end else begin
            ren_valid   <= ren_req;
            cpu_overrun <= cpu_stb && !accept;
            if (accept)
                slot <= '{op: (cpu_data_rd_stb ? OP_RD : OP_WR), addr: v_masked, data: cpu_wdata};
            // palette reads bypass the one-read-behind buffer
            if (state == RD_WAIT) begin
                rd_buf    <= vram.VRAM_data_out;
                cpu_rdata <= (slot.addr >= PAL_BASE) ? vram.VRAM_data_out : rd_buf;
            end
        end
    end
endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Scoreboard bench: stimulus pushes expected VRAM writes, $2007 read results
// and render bytes; independent monitors pop and compare as the DUT presents them.
module tb_ppu_vram_arbiter;
    logic        clk = 1'b0, reset = 1'b0;
    logic        cpu_addr_wr_stb = 1'b0, cpu_data_wr_stb = 1'b0, cpu_data_rd_stb = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        incr32 = 1'b0, w_clear = 1'b0, ren_req = 1'b0;
    logic [15:0] ren_addr = 16'h0;
    logic [7:0]  cpu_rdata, ren_data;
    logic        cpu_busy, cpu_overrun, ren_valid;
    logic [14:0] vaddr;

    ppu_vram_arbiter_if vif();

    ppu_vram_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_addr_wr_stb(cpu_addr_wr_stb), .cpu_data_wr_stb(cpu_data_wr_stb),
        .cpu_data_rd_stb(cpu_data_rd_stb), .cpu_wdata(cpu_wdata),
        .incr32(incr32), .w_clear(w_clear),
        .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy), .cpu_overrun(cpu_overrun),
        .vaddr(vaddr), .ren_req(ren_req), .ren_addr(ren_addr),
        .ren_data(ren_data), .ren_valid(ren_valid), .vram(vif)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 37) ^ (a >> 8));
    endfunction

    // VRAM device: unwritten locations read back the fill pattern
    logic [7:0] vmem    [65536];
    bit         written [65536];
    always @(posedge clk) begin
        if (vif.VRAM_WE) begin
            vmem[vif.VRAM_addr]    <= vif.VRAM_data_in;
            written[vif.VRAM_addr] <= 1'b1;
        end
        vif.VRAM_data_out <= written[vif.VRAM_addr] ? vmem[vif.VRAM_addr] : pat(int'(vif.VRAM_addr));
    end

    typedef struct { logic [15:0] addr; logic [7:0] data; } wr_t;
    wr_t        wr_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] ren_q[$];
    int         ovr_exp = 0;
    int         vec = 0, errs = 0;

    logic [7:0]  ref_mem [65536];
    logic [14:0] ref_v = '0;
    bit          ref_w = 1'b0;
    logic [7:0]  ref_rd_buf = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        vec++;
        errs++;
        $display("FAIL %s: output presented with nothing expected", name);
    endtask

    // ---------------- monitors ----------------
    bit prev_busy = 1'b0, prev_we = 1'b0;
    always @(negedge clk) begin
        wr_t        e;
        logic [7:0] x;
        if (vif.VRAM_WE) begin
            chk("we_during_ren", ren_req, 0);
            if (wr_q.size() == 0) fail_evt("vram_write");
            else begin
                e = wr_q.pop_front();
                chk("wr_addr", vif.VRAM_addr, e.addr);
                chk("wr_data", vif.VRAM_data_in, e.data);
            end
        end
        if (ren_valid) begin
            if (ren_q.size() == 0) fail_evt("ren_valid");
            else begin
                x = ren_q.pop_front();
                chk("ren_data", ren_data, x);
            end
        end
        // a busy fall not preceded by a write pulse completes a read
        if (reset && prev_busy && !cpu_busy && !prev_we) begin
            if (rd_q.size() == 0) fail_evt("read_done");
            else begin
                x = rd_q.pop_front();
                chk("cpu_rdata", cpu_rdata, x);
            end
        end
        if (cpu_overrun) begin
            if (ovr_exp == 0) fail_evt("cpu_overrun");
            else begin
                vec++;
                ovr_exp--;
            end
        end
        prev_busy = cpu_busy;
        prev_we   = vif.VRAM_WE;
    end

    // ---------------- stimulus + reference model ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [7:0] d, input bit clr = 1'b0);
        tick();
        cpu_addr_wr_stb = 1'b1; cpu_wdata = d; w_clear = clr;
        if (!ref_w) ref_v = {1'b0, d[5:0], ref_v[7:0]};
        else        ref_v[7:0] = d;
        ref_w = clr ? 1'b0 : !ref_w;
        tick();
        cpu_addr_wr_stb = 1'b0; w_clear = 1'b0;
    endtask

    task automatic wclear();
        tick();
        w_clear = 1'b1; ref_w = 1'b0;
        tick();
        w_clear = 1'b0;
    endtask

    task automatic model_op(input bit rd, input logic [7:0] d);
        logic [15:0] a;
        a = {1'b0, ref_v} & 16'h3FFF;
        if (rd) begin
            rd_q.push_back(a >= 16'h3F00 ? ref_mem[a] : ref_rd_buf);
            ref_rd_buf = ref_mem[a];
        end else begin
            wr_q.push_back('{a, d});
            ref_mem[a] = d;
        end
        ref_v = ref_v + (incr32 ? 15'd32 : 15'd1);
    endtask

    task automatic drive_ren();
        ren_req  = 1'b1;
        ren_addr = 16'($urandom_range(0, 16'h1FFF));
        ren_q.push_back(ref_mem[ren_addr]);
    endtask

    // one $2007 access with `len` cycles of render traffic starting alongside it
    task automatic cpu_op(input bit rd, input logic [7:0] d, input int len, input bit ovr);
        tick();
        cpu_data_rd_stb = rd; cpu_data_wr_stb = !rd; cpu_wdata = d;
        model_op(rd, d);
        if (len > 0) drive_ren(); else ren_req = 1'b0;
        for (int i = 1; i < len; i++) begin
            tick();
            cpu_data_rd_stb = 1'b0; cpu_data_wr_stb = 1'b0;
            if (i == 1 && ovr) begin
                cpu_data_wr_stb = 1'b1; cpu_wdata = ~d; ovr_exp++;
            end
            drive_ren();
        end
        tick();
        cpu_data_rd_stb = 1'b0; cpu_data_wr_stb = 1'b0; ren_req = 1'b0;
        repeat (5) tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
        chk({tag, "_cpu_busy"}, cpu_busy, 0);
        chk({tag, "_cpu_overrun"}, cpu_overrun, 0);
        chk({tag, "_vaddr"}, vaddr, 0);
        chk({tag, "_ren_valid"}, ren_valid, 0);
        chk({tag, "_ren_data"}, ren_data, 0);
        chk({tag, "_vram_addr"}, vif.VRAM_addr, 0);
        chk({tag, "_vram_we"}, vif.VRAM_WE, 0);
        chk({tag, "_vram_din"}, vif.VRAM_data_in, 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = pat(i);
        #1;
        check_zero("reset");
        tick();
        reset = 1'b1;

        // $2006 sequencing and w handling
        set_addr(8'h21); set_addr(8'h08);
        chk("vaddr_2108", vaddr, 15'h2108);
        wclear(); set_addr(8'h3F);
        chk("vaddr_hi_3f", vaddr[14:8], 7'h3F);
        wclear(); set_addr(8'h25); set_addr(8'h3F, 1'b1); set_addr(8'h2A);
        chk("vaddr_wclear_same", vaddr, ref_v);

        // single write
        wclear(); set_addr(8'h20); set_addr(8'h00);
        incr32 = 1'b0;
        cpu_op(1'b0, 8'hAB, 0, 1'b0);
        chk("vaddr_2001", vaddr, 15'h2001);

        // buffered reads with +32
        set_addr(8'h23); set_addr(8'hE0);
        incr32 = 1'b1;
        cpu_op(1'b1, 8'h00, 0, 1'b0);
        cpu_op(1'b1, 8'h00, 0, 1'b0);
        chk("vaddr_2420", vaddr, 15'h2420);

        // palette read is unbuffered
        incr32 = 1'b0;
        set_addr(8'h3F); set_addr(8'h00);
        cpu_op(1'b0, 8'h0F, 0, 1'b0);
        set_addr(8'h3F); set_addr(8'h00);
        cpu_op(1'b1, 8'h00, 0, 1'b0);
        chk("vaddr_3f01", vaddr, 15'h3F01);

        // render holds the port for 10 cycles; a second strobe is dropped
        set_addr(8'h2C); set_addr(8'h40);
        cpu_op(1'b0, 8'hC3, 10, 1'b1);
        chk("vaddr_after_ovr", vaddr, 15'h2C41);

        // strobe accepted in the same cycle the slot frees
        tick();
        cpu_data_wr_stb = 1'b1; cpu_wdata = 8'h11; model_op(1'b0, 8'h11);
        tick();
        cpu_wdata = 8'h22; model_op(1'b0, 8'h22);
        tick();
        cpu_data_wr_stb = 1'b0;
        repeat (5) tick();
        chk("vaddr_b2b", vaddr, ref_v);

        // randomized traffic
        for (int it = 0; it < 120; it++) begin
            logic [7:0] hi, lo;
            int         nops, len;
            bit         rd, ovr;
            hi = 8'($urandom_range(8'h20, 8'h3E));
            lo = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                hi = 8'h3F;
                lo = 8'($urandom_range(0, 8'h9F));
            end
            wclear(); set_addr(hi); set_addr(lo);
            chk("rand_vaddr_set", vaddr, ref_v);
            incr32 = 1'($urandom);
            nops = $urandom_range(1, 3);
            for (int k = 0; k < nops; k++) begin
                rd  = 1'($urandom);
                len = $urandom_range(0, 5);
                ovr = (len >= 2) && ($urandom_range(0, 3) == 0);
                cpu_op(rd, 8'($urandom), len, ovr);
                chk("rand_vaddr_op", vaddr, ref_v);
            end
        end

        // async reset while a write waits in ISSUE behind render
        incr32 = 1'b0;
        set_addr(8'h2D); set_addr(8'h10);
        tick();
        ren_req = 1'b1; ren_addr = 16'h0123; ren_q.push_back(ref_mem[16'h0123]);
        cpu_data_wr_stb = 1'b1; cpu_wdata = 8'h5A;
        tick();
        cpu_data_wr_stb = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_zero("mid_issue");
        ren_req = 1'b0;
        ren_q.delete(); wr_q.delete(); rd_q.delete();
        ovr_exp = 0; ref_v = '0; ref_w = 1'b0; ref_rd_buf = 8'h00;
        repeat (3) tick();
        reset = 1'b1;
        set_addr(8'h2D); set_addr(8'h10);
        cpu_op(1'b1, 8'h00, 0, 1'b0);
        chk("post_reset_vaddr", vaddr, 15'h2D11);

        repeat (4) tick();
        chk("wr_q_left", wr_q.size(), 0);
        chk("rd_q_left", rd_q.size(), 0);
        chk("ren_q_left", ren_q.size(), 0);
        chk("ovr_left", ovr_exp, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
